// File: rtl/fan_ctrl_scheduler.sv
// Central fan sequencer: off/run/blocked state, button arbitration,
// shut-off countdown, proximity blocking and motor duty ramp.
module fan_ctrl_scheduler #(
    parameter int SEC_DIV   = 100_000_000,
    parameter int RAMP_DIV  = 1_000_000,
    parameter int RAMP_STEP = 5,
    parameter int NEAR_CM   = 10,
    parameter int NEAR_HOLD = 3,
    parameter int DUTY_L1   = 85,
    parameter int DUTY_L2   = 170,
    parameter int DUTY_L3   = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_speed,
    input  logic        btn_timer,
    input  logic        btn_swing,
    input  logic [11:0] distance,
    input  logic        distance_valid,
    output logic [7:0]  duty,
    output logic [1:0]  speed_level,
    output logic [2:0]  motor_led,
    output logic [1:0]  timer_sel,
    output logic [2:0]  timer_led,
    output logic [8:0]  remaining_s,
    output logic        swing_out,
    output logic        blocked
);

    localparam int SEC_W  = (SEC_DIV  > 1) ? $clog2(SEC_DIV)  : 1;
    localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int NEAR_W = $clog2(NEAR_HOLD + 1);

    localparam logic [SEC_W-1:0]  SEC_LAST   = SEC_W'(SEC_DIV - 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST  = RAMP_W'(RAMP_DIV - 1);
    localparam logic [NEAR_W-1:0] NEAR_LAST  = NEAR_W'(NEAR_HOLD - 1);
    localparam logic [7:0]        STEP       = 8'(RAMP_STEP);
    localparam logic [11:0]       NEAR_LIMIT = 12'(NEAR_CM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BLOCK = 2'd2
    } state_t;

    function automatic logic [2:0] one_hot(input logic [1:0] sel);
        case (sel)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [8:0] timer_load(input logic [1:0] sel);
        case (sel)
            2'd1:    return 9'd60;
            2'd2:    return 9'd180;
            2'd3:    return 9'd300;
            default: return 9'd0;
        endcase
    endfunction

    function automatic logic [7:0] level_duty(input logic [1:0] lvl);
        case (lvl)
            2'd1:    return 8'(DUTY_L1);
            2'd2:    return 8'(DUTY_L2);
            2'd3:    return 8'(DUTY_L3);
            default: return 8'd0;
        endcase
    endfunction

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          level_nxt;
    logic [1:0]          timer_nxt;
    logic [8:0]          remaining_nxt;
    logic                swing_en;
    logic                swing_nxt;
    logic [SEC_W-1:0]    sec_cnt;
    logic [SEC_W-1:0]    sec_nxt;
    logic [NEAR_W-1:0]   near_cnt;
    logic [NEAR_W-1:0]   near_nxt;
    logic [RAMP_W-1:0]   ramp_cnt;
    logic [7:0]          target;
    logic [7:0]          duty_nxt;
    logic [7:0]          duty_gap;

    logic count_active;
    logic sec_tick;
    logic expire;
    logic sample_ok;
    logic is_near;
    logic qualifying;
    logic ramp_tick;

    assign count_active = (timer_sel != 2'd0) && (state != IDLE);
    assign sec_tick     = count_active && (sec_cnt == SEC_LAST);
    assign expire       = sec_tick && (remaining_s == 9'd1);
    assign sample_ok    = distance_valid && (distance != 12'd0);
    assign is_near      = distance < NEAR_LIMIT;
    assign qualifying   = (state == RUN) ? is_near : !is_near;
    assign ramp_tick    = (ramp_cnt == RAMP_LAST);

    // Expiry overrides everything; otherwise one button wins by priority and
    // proximity only acts when no button already moved the state.
    always_comb begin
        state_nxt     = state;
        level_nxt     = speed_level;
        timer_nxt     = timer_sel;
        remaining_nxt = remaining_s;
        swing_nxt     = swing_en;
        sec_nxt       = sec_cnt;
        near_nxt      = near_cnt;

        if (expire) begin
            state_nxt     = IDLE;
            level_nxt     = 2'd0;
            timer_nxt     = 2'd0;
            remaining_nxt = 9'd0;
            swing_nxt     = 1'b0;
            sec_nxt       = '0;
            near_nxt      = '0;
        end else begin
            if (count_active) begin
                if (sec_tick) begin
                    remaining_nxt = remaining_s - 9'd1;
                    sec_nxt       = '0;
                end else begin
                    sec_nxt = sec_cnt + 1'b1;
                end
            end

            if (btn_speed) begin
                if (state == IDLE) begin
                    state_nxt = RUN;
                    level_nxt = 2'd1;
                end else if (speed_level == 2'd3) begin
                    state_nxt = IDLE;
                    level_nxt = 2'd0;
                    swing_nxt = 1'b0;
                end else begin
                    level_nxt = speed_level + 2'd1;
                end
            end else if (btn_timer && state != IDLE) begin
                timer_nxt     = timer_sel + 2'd1;
                remaining_nxt = timer_load(timer_sel + 2'd1);
                sec_nxt       = '0;
            end else if (btn_swing && state != IDLE) begin
                swing_nxt = !swing_en;
            end

            // Counter tracks consecutive samples that argue for leaving the current state.
            if (state_nxt != state || state == IDLE) begin
                near_nxt = '0;
            end else if (sample_ok) begin
                if (!qualifying) begin
                    near_nxt = '0;
                end else if (near_cnt == NEAR_LAST) begin
                    state_nxt = (state == RUN) ? BLOCK : RUN;
                    near_nxt  = '0;
                end else begin
                    near_nxt = near_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            speed_level <= 2'd0;
            timer_sel   <= 2'd0;
            remaining_s <= 9'd0;
            swing_en    <= 1'b0;
            sec_cnt     <= '0;
            near_cnt    <= '0;
            motor_led   <= 3'b000;
            timer_led   <= 3'b000;
            swing_out   <= 1'b0;
            blocked     <= 1'b0;
        end else begin
            state       <= state_nxt;
            speed_level <= level_nxt;
            timer_sel   <= timer_nxt;
            remaining_s <= remaining_nxt;
            swing_en    <= swing_nxt;
            sec_cnt     <= sec_nxt;
            near_cnt    <= near_nxt;
            motor_led   <= one_hot(level_nxt);
            timer_led   <= one_hot(timer_nxt);
            swing_out   <= swing_nxt && (state_nxt == RUN);
            blocked     <= (state_nxt == BLOCK);
        end
    end

    // Ramp lands exactly on the target when within one step, so no overshoot.
    always_comb begin
        target   = (state == RUN) ? level_duty(speed_level) : 8'd0;
        duty_nxt = duty;
        duty_gap = 8'd0;
        if (duty < target) begin
            duty_gap = target - duty;
            duty_nxt = (duty_gap <= STEP) ? target : duty + STEP;
        end else if (duty > target) begin
            duty_gap = duty - target;
            duty_nxt = (duty_gap <= STEP) ? target : duty - STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ramp_cnt <= '0;
            duty     <= 8'd0;
        end else begin
            ramp_cnt <= ramp_tick ? '0 : ramp_cnt + 1'b1;
            if (ramp_tick) begin
                duty <= duty_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fan_ctrl_scheduler.sv
// Self-checking bench for fan_ctrl_scheduler: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a behavioural model.
module tb_fan_ctrl_scheduler;

    localparam int SEC_DIV   = 20;
    localparam int RAMP_DIV  = 4;
    localparam int RAMP_STEP = 85;
    localparam int NEAR_CM   = 10;
    localparam int NEAR_HOLD = 3;

    localparam int OFF  = 0;
    localparam int ON   = 1;
    localparam int HALT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        btn_speed;
    logic        btn_timer;
    logic        btn_swing;
    logic [11:0] distance;
    logic        distance_valid;
    logic [7:0]  duty;
    logic [1:0]  speed_level;
    logic [2:0]  motor_led;
    logic [1:0]  timer_sel;
    logic [2:0]  timer_led;
    logic [8:0]  remaining_s;
    logic        swing_out;
    logic        blocked;

    fan_ctrl_scheduler #(
        .SEC_DIV   (SEC_DIV),
        .RAMP_DIV  (RAMP_DIV),
        .RAMP_STEP (RAMP_STEP),
        .NEAR_CM   (NEAR_CM),
        .NEAR_HOLD (NEAR_HOLD),
        .DUTY_L1   (85),
        .DUTY_L2   (170),
        .DUTY_L3   (255)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .btn_speed      (btn_speed),
        .btn_timer      (btn_timer),
        .btn_swing      (btn_swing),
        .distance       (distance),
        .distance_valid (distance_valid),
        .duty           (duty),
        .speed_level    (speed_level),
        .motor_led      (motor_led),
        .timer_sel      (timer_sel),
        .timer_led      (timer_led),
        .remaining_s    (remaining_s),
        .swing_out      (swing_out),
        .blocked        (blocked)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit check_en     = 1'b0;

    int m_mode, m_level, m_timer, m_remaining, m_swing;
    int m_sec, m_ramp, m_near, m_duty;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    function automatic int level_target(input int lvl);
        case (lvl)
            1:       return 85;
            2:       return 170;
            3:       return 255;
            default: return 0;
        endcase
    endfunction

    function automatic int led_of(input int sel);
        return (sel == 0) ? 0 : (1 << (sel - 1));
    endfunction

    task automatic model_reset();
        m_mode = OFF; m_level = 0; m_timer = 0; m_remaining = 0; m_swing = 0;
        m_sec = 0; m_ramp = 0; m_near = 0; m_duty = 0;
    endtask

    // One clock of fan behaviour, computed from the operating rules with plain integers.
    task automatic model_step();
        int target;
        bit active;
        bit tick;
        bit changed;
        bit qualifying;

        if (m_ramp == RAMP_DIV - 1) begin
            m_ramp = 0;
            target = (m_mode == ON) ? level_target(m_level) : 0;
            if (m_duty < target)
                m_duty = (m_duty + RAMP_STEP > target) ? target : m_duty + RAMP_STEP;
            else if (m_duty > target)
                m_duty = (m_duty - RAMP_STEP < target) ? target : m_duty - RAMP_STEP;
        end else begin
            m_ramp++;
        end

        active = (m_timer != 0) && (m_mode != OFF);
        tick   = active && (m_sec == SEC_DIV - 1);
        if (tick && m_remaining == 1) begin
            m_mode = OFF; m_level = 0; m_timer = 0; m_remaining = 0;
            m_swing = 0; m_sec = 0; m_near = 0;
            return;
        end
        if (active) begin
            if (tick) begin
                m_remaining--;
                m_sec = 0;
            end else begin
                m_sec++;
            end
        end

        changed = 1'b0;
        if (btn_speed) begin
            if (m_mode == OFF) begin
                m_mode = ON; m_level = 1; changed = 1'b1;
            end else if (m_level == 3) begin
                m_mode = OFF; m_level = 0; m_swing = 0; changed = 1'b1;
            end else begin
                m_level++;
            end
        end else if (btn_timer && m_mode != OFF) begin
            m_timer     = (m_timer + 1) % 4;
            m_remaining = (m_timer == 0) ? 0 : (2 * m_timer - 1) * 60;
            m_sec       = 0;
        end else if (btn_swing && m_mode != OFF) begin
            m_swing = !m_swing;
        end

        if (changed || m_mode == OFF) begin
            m_near = 0;
        end else if (distance_valid && distance != 0) begin
            qualifying = (m_mode == ON) ? (distance < NEAR_CM) : (distance >= NEAR_CM);
            if (!qualifying) begin
                m_near = 0;
            end else begin
                m_near++;
                if (m_near == NEAR_HOLD) begin
                    m_mode = (m_mode == ON) ? HALT : ON;
                    m_near = 0;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("duty",        int'(duty),        m_duty);
            checkOutput("speed_level", int'(speed_level), m_level);
            checkOutput("motor_led",   int'(motor_led),   led_of(m_level));
            checkOutput("timer_sel",   int'(timer_sel),   m_timer);
            checkOutput("timer_led",   int'(timer_led),   led_of(m_timer));
            checkOutput("remaining_s", int'(remaining_s), m_remaining);
            checkOutput("swing_out",   int'(swing_out),   (m_swing != 0 && m_mode == ON) ? 1 : 0);
            checkOutput("blocked",     int'(blocked),     (m_mode == HALT) ? 1 : 0);
        end
    end

    // Drives one cycle of inputs starting at a falling edge; returns at the next falling edge.
    task automatic applyStimulus(input bit s, input bit t, input bit w, input bit v, input int d);
        btn_speed      = s;
        btn_timer      = t;
        btn_swing      = w;
        distance_valid = v;
        distance       = 12'(d);
        @(negedge clk);
        btn_speed      = 1'b0;
        btn_timer      = 1'b0;
        btn_swing      = 1'b0;
        distance_valid = 1'b0;
        distance       = 12'd0;
    endtask

    task automatic sample(input int d);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".duty"},        int'(duty),        0);
        checkOutput({tag, ".speed_level"}, int'(speed_level), 0);
        checkOutput({tag, ".motor_led"},   int'(motor_led),   0);
        checkOutput({tag, ".timer_sel"},   int'(timer_sel),   0);
        checkOutput({tag, ".timer_led"},   int'(timer_led),   0);
        checkOutput({tag, ".remaining_s"}, int'(remaining_s), 0);
        checkOutput({tag, ".swing_out"},   int'(swing_out),   0);
        checkOutput({tag, ".blocked"},     int'(blocked),     0);
    endtask

    initial begin
        reset_n        = 1'b0;
        btn_speed      = 1'b0;
        btn_timer      = 1'b0;
        btn_swing      = 1'b0;
        distance       = 12'd0;
        distance_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_en = 1'b1;
        checkAllZero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] speed cycling");
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("spd1.level", int'(speed_level), 1);
        checkOutput("spd1.led",   int'(motor_led),   1);
        repeat (100) @(negedge clk);
        checkOutput("spd1.duty",  int'(duty),        85);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("spd2.led",   int'(motor_led),   2);
        repeat (100) @(negedge clk);
        checkOutput("spd2.duty",  int'(duty),        170);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("spd3.led",   int'(motor_led),   4);
        repeat (100) @(negedge clk);
        checkOutput("spd3.duty",  int'(duty),        255);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("spd0.level", int'(speed_level), 0);
        checkOutput("spd0.led",   int'(motor_led),   0);
        repeat (100) @(negedge clk);
        checkOutput("spd0.duty",  int'(duty),        0);

        $display("[TB] timer expiry");
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        repeat (20) @(negedge clk);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("tmr.sel",       int'(timer_sel),   1);
        checkOutput("tmr.led",       int'(timer_led),   1);
        checkOutput("tmr.load",      int'(remaining_s), 60);
        repeat (20) @(negedge clk);
        checkOutput("tmr.first_dec", int'(remaining_s), 59);
        repeat (1160) @(negedge clk);
        checkOutput("tmr.last_sec",  int'(remaining_s), 1);
        checkOutput("tmr.still_l2",  int'(speed_level), 2);
        repeat (20) @(negedge clk);
        checkOutput("tmr.exp_level", int'(speed_level), 0);
        checkOutput("tmr.exp_sel",   int'(timer_sel),   0);
        checkOutput("tmr.exp_rem",   int'(remaining_s), 0);
        repeat (8) @(negedge clk);
        checkOutput("tmr.exp_duty",  int'(duty),        0);

        $display("[TB] proximity block");
        repeat (3) applyStimulus(1, 0, 0, 0, 0);
        repeat (20) @(negedge clk);
        checkOutput("prox.run_duty", int'(duty), 255);
        sample(5);
        sample(5);
        sample(0);
        checkOutput("prox.zero_ignored", int'(blocked), 0);
        sample(5);
        checkOutput("prox.blocked",  int'(blocked),     1);
        checkOutput("prox.level_kept", int'(speed_level), 3);
        repeat (12) @(negedge clk);
        checkOutput("prox.blk_duty", int'(duty), 0);
        sample(20);
        sample(5);
        sample(20);
        sample(20);
        checkOutput("prox.still_blk", int'(blocked), 1);
        sample(20);
        checkOutput("prox.released", int'(blocked), 0);
        repeat (12) @(negedge clk);
        checkOutput("prox.rel_duty", int'(duty), 255);

        $display("[TB] simultaneous pulses");
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("sim.idle", int'(speed_level), 0);
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("sim.level", int'(speed_level), 1);
        checkOutput("sim.timer", int'(timer_sel),   0);
        checkOutput("sim.swing", int'(swing_out),   0);

        $display("[TB] swing gating");
        repeat (3) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("swg.idle", int'(swing_out), 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("swg.run_off", int'(swing_out), 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("swg.run_on", int'(swing_out), 1);
        repeat (3) sample(5);
        checkOutput("swg.blk", int'(swing_out), 0);
        repeat (3) sample(20);
        checkOutput("swg.restore", int'(swing_out), 1);

        $display("[TB] mid-operation reset");
        applyStimulus(1, 0, 0, 0, 0);
        repeat (20) @(negedge clk);
        applyStimulus(0, 1, 0, 0, 0);
        repeat (460) @(negedge clk);
        checkOutput("mrst.rem",  int'(remaining_s), 37);
        checkOutput("mrst.duty", int'(duty),        170);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checkAllZero("mrst");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 6000; i++) begin
            reset_n        = ($urandom_range(0, 2999) != 0);
            btn_speed      = ($urandom_range(0, 39) == 0);
            btn_timer      = ($urandom_range(0, 199) == 0);
            btn_swing      = ($urandom_range(0, 29) == 0);
            distance_valid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0:       distance = 12'd0;
                1:       distance = 12'($urandom_range(1, 9));
                2:       distance = ($urandom_range(0, 1) == 0) ? 12'd9 : 12'd10;
                default: distance = 12'($urandom_range(10, 4095));
            endcase
            @(negedge clk);
        end
        reset_n        = 1'b1;
        btn_speed      = 1'b0;
        btn_timer      = 1'b0;
        btn_swing      = 1'b0;
        distance_valid = 1'b0;
        distance       = 12'd0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
